led_matrix_scan: RTL



---
 rtl/led_scan_pkg.sv | 23 ++
 rtl/scan_tick_gen.sv | 37 +++
 rtl/led_matrix_scan.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/led_scan_pkg.sv
// Shared types and constants for the LED matrix column scan driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_scan_pkg;

  typedef enum logic [2:0] {
    INIT,
    LOAD,
    SHIFT,
    LATCH,
    DISPLAY
  } scan_state_t;

  // One bit per LED in a column: 8 red, 8 green, 8 blue.
  localparam int SHIFT_BITS = 24;
  // Ticks the external shift-register chain is held in reset after power-up.
  localparam int INIT_TICKS = 4;

  function automatic logic [7:0] col_onehot(input logic [2:0] col);
    col_onehot = 8'b1 << col;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Scan tick generator: one-clk strobe every CLK_DIV clk cycles.
// Latency: first tick CLK_DIV-1 cycles after reset release, then every CLK_DIV.
// Backpressure: none; free-running.
//
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset; clears the divider
//   tick  - registered one-clk strobe
module scan_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  // tick is registered off the cycle before the wrap so it lines up with
  // cnt == CLK_DIV-1 without a decode path on the output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      if (cnt == CW'(CLK_DIV - 1)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      tick <= (cnt == CW'(CLK_DIV - 2));
    end
  end

endmodule

// File: rtl/led_matrix_scan.sv
// Column-multiplexed scan driver for an 8x8 RGB LED module with a serial shift-register chain.
// Latency: column period = (1 + 48 + 2 + HOLD_TICKS) ticks; every output is registered.
// Backpressure: none; upstream must present column col_num's vectors by the LOAD tick.
//
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   red/green/blue_vect_in - column data for col_num, sampled only at LOAD
//   col_num              - column being loaded/displayed (stable from previous DISPLAY exit)
//   col_data_capture     - one-clk pulse when the input vectors are sampled
//   reset_out, OE        - shift-register reset and output enable, both active low
//   SH_CP, ST_CP, DS     - shift clock, storage clock, serial data (1 = LED on)
//   col_select           - one-hot active column, high only during DISPLAY
//   bright               - (LED_MATRIX_DIM_EN only) on-time = (bright+1)/4 of DISPLAY
//
// Build option: define LED_MATRIX_DIM_EN to add the bright input and OE dimming.
module led_matrix_scan #(
  parameter int CLK_DIV    = 2,
  parameter int HOLD_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] red_vect_in,
  input  logic [7:0] green_vect_in,
  input  logic [7:0] blue_vect_in,
  output logic [2:0] col_num,
  output logic       col_data_capture,
  output logic       reset_out,
  output logic       OE,
  output logic       SH_CP,
  output logic       ST_CP,
  output logic       DS,
  output logic [7:0] col_select
`ifdef LED_MATRIX_DIM_EN
  ,
  input  logic [1:0] bright
`endif
);

  import led_scan_pkg::*;

  // One shared tick counter serves every state; size it for the longest one.
  localparam int CNT_MAX = (HOLD_TICKS > 2 * SHIFT_BITS) ? HOLD_TICKS : 2 * SHIFT_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX);

  logic tick;

  scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  scan_state_t           state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [SHIFT_BITS-1:0] shreg, shreg_nxt;
  logic [2:0]            col_num_nxt;
  logic                  capture_nxt;
  logic                  reset_out_nxt;
  logic                  oe_nxt;
  logic                  sh_cp_nxt;
  logic                  st_cp_nxt;
  logic                  ds_nxt;
  logic [7:0]            col_select_nxt;

`ifdef LED_MATRIX_DIM_EN
  logic [1:0]   bright_q, bright_nxt;
  logic [CNT_W:0] on_ticks;

  assign on_ticks = (CNT_W + 1)'((32'(bright_q) + 32'd1) * 32'(HOLD_TICKS / 4));
`endif

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    shreg_nxt      = shreg;
    col_num_nxt    = col_num;
    capture_nxt    = 1'b0;
    reset_out_nxt  = reset_out;
    oe_nxt         = OE;
    sh_cp_nxt      = SH_CP;
    st_cp_nxt      = ST_CP;
    ds_nxt         = DS;
    col_select_nxt = col_select;
`ifdef LED_MATRIX_DIM_EN
    bright_nxt     = bright_q;
`endif

    if (tick) begin
      unique case (state)
        INIT: begin
          reset_out_nxt = 1'b0;
          oe_nxt        = 1'b1;
          if (cnt == CNT_W'(INIT_TICKS - 1)) begin
            state_nxt     = LOAD;
            cnt_nxt       = '0;
            reset_out_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end

        LOAD: begin
          shreg_nxt   = {red_vect_in, green_vect_in, blue_vect_in};
          capture_nxt = 1'b1;
`ifdef LED_MATRIX_DIM_EN
          bright_nxt  = bright;
`endif
          state_nxt   = SHIFT;
          cnt_nxt     = '0;
        end

        SHIFT: begin
          // Even tick presents the MSB with the shift clock low; odd tick
          // raises the clock and advances the register behind it, so DS
          // never moves while SH_CP is high.
          if (!cnt[0]) begin
            ds_nxt    = shreg[SHIFT_BITS-1];
            sh_cp_nxt = 1'b0;
          end else begin
            sh_cp_nxt = 1'b1;
            shreg_nxt = {shreg[SHIFT_BITS-2:0], 1'b0};
          end
          if (cnt == CNT_W'(2 * SHIFT_BITS - 1)) begin
            state_nxt = LATCH;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end

        LATCH: begin
          sh_cp_nxt = 1'b0;
          if (cnt == '0) begin
            st_cp_nxt = 1'b1;
            cnt_nxt   = CNT_W'(1);
          end else begin
            st_cp_nxt      = 1'b0;
            state_nxt      = DISPLAY;
            cnt_nxt        = '0;
            col_select_nxt = col_onehot(col_num);
            oe_nxt         = 1'b0;
          end
        end

        DISPLAY: begin
          if (cnt == CNT_W'(HOLD_TICKS - 1)) begin
            col_num_nxt    = col_num + 3'd1;
            col_select_nxt = '0;
            oe_nxt         = 1'b1;
            state_nxt      = LOAD;
            cnt_nxt        = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
`ifdef LED_MATRIX_DIM_EN
            // cnt+1 display ticks have elapsed once this tick retires.
            if (({1'b0, cnt} + (CNT_W + 1)'(1)) >= on_ticks) begin
              oe_nxt = 1'b1;
            end
`endif
          end
        end

        default: begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= INIT;
      cnt              <= '0;
      shreg            <= '0;
      col_num          <= '0;
      col_data_capture <= 1'b0;
      reset_out        <= 1'b0;
      OE               <= 1'b1;
      SH_CP            <= 1'b0;
      ST_CP            <= 1'b0;
      DS               <= 1'b0;
      col_select       <= '0;
`ifdef LED_MATRIX_DIM_EN
      bright_q         <= '0;
`endif
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      shreg            <= shreg_nxt;
      col_num          <= col_num_nxt;
      col_data_capture <= capture_nxt;
      reset_out        <= reset_out_nxt;
      OE               <= oe_nxt;
      SH_CP            <= sh_cp_nxt;
      ST_CP            <= st_cp_nxt;
      DS               <= ds_nxt;
      col_select       <= col_select_nxt;
`ifdef LED_MATRIX_DIM_EN
      bright_q         <= bright_nxt;
`endif
    end
  end

endmodule
